// File: rtl/spi_inert_resp.sv
// SPI responder for an inertial sensor: register map, sample capture and INT flag.
// Latency: synchronizers add about 3 clk from an SPI pin edge to the internal edge event;
//   MISO follows about 3 clk after an SCLK fall. Backpressure: none; smpl_vld is never stalled.
//   Samples that arrive during a frame are parked and captured when the frame ends.
// Ports: clk/rst       - system clock, async active-high reset
//        SS_n/SCLK/MOSI - SPI from the master (asynchronous; SCLK idles high)
//        MISO          - read data, MSB first, updated after SCLK falls
//        INT           - new-sample flag
//        smpl_vld, ptch_rt/roll_rt/yaw_rt - sensor sample strobe and 16-bit rates
module spi_inert_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state_q;
  logic [2:0]  ss_q, sclk_q;   // [1:0] synchronizer, [2] previous value for edge detect
  logic [1:0]  mosi_q;
  logic [4:0]  cnt_q;
  logic [15:0] rx_q;
  logic [7:0]  tx_q;
  logic        tx_ld_q;        // read data already loaded into tx for this frame
  logic [7:0]  int1_ctrl_q, ctrl1_q, ctrl2_q;
  logic [15:0] ptch_q, roll_q, yaw_q;
  logic [15:0] pend_ptch_q, pend_roll_q, pend_yaw_q;
  logic        pend_vld_q;
  logic        int_set_q, int_q;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic        in_commit, frame_ok, wr_en, int_clr, cap_en, use_pend;
  logic [15:0] cap_ptch_d, cap_roll_d, cap_yaw_d;
  logic [7:0]  rd_dat;
  logic        int_d;

  // SS_n sync resets low so a select that is still low after reset never
  // looks like a fresh fall; the master must deselect and select again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q   <= 3'b000;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign ss_fall   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

  assign in_commit = (state_q == COMMIT);
  assign frame_ok  = (cnt_q == 5'd16);
  assign wr_en     = in_commit & frame_ok & ~rx_q[15];
  // Clear on a complete read of yaw H, or on a write that disables the INT enable.
  assign int_clr   = (in_commit & frame_ok & rx_q[15] & (rx_q[14:8] == 7'h27)) |
                     (wr_en & (rx_q[14:8] == 7'h0D) & ~rx_q[1]);

  // Capture directly when idle; at frame end take a same-cycle sample over the parked one.
  assign cap_en     = ((state_q == IDLE) & smpl_vld) | (in_commit & (smpl_vld | pend_vld_q));
  assign use_pend   = in_commit & ~smpl_vld;
  assign cap_ptch_d = use_pend ? pend_ptch_q : ptch_rt;
  assign cap_roll_d = use_pend ? pend_roll_q : roll_rt;
  assign cap_yaw_d  = use_pend ? pend_yaw_q  : yaw_rt;

  // Set has priority over clear.
  assign int_d = int_set_q ? 1'b1 : (int_clr ? 1'b0 : int_q);

  // Address sits in rx[6:0] once the first byte has been shifted in.
  always_comb begin
    rd_dat = 8'h00;
    case (rx_q[6:0])
      7'h0F:   rd_dat = 8'h6A;
      7'h0D:   rd_dat = int1_ctrl_q;
      7'h10:   rd_dat = ctrl1_q;
      7'h11:   rd_dat = ctrl2_q;
      7'h22:   rd_dat = ptch_q[7:0];
      7'h23:   rd_dat = ptch_q[15:8];
      7'h24:   rd_dat = roll_q[7:0];
      7'h25:   rd_dat = roll_q[15:8];
      7'h26:   rd_dat = yaw_q[7:0];
      7'h27:   rd_dat = yaw_q[15:8];
      default: rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      rx_q        <= 16'h0000;
      tx_q        <= 8'h00;
      tx_ld_q     <= 1'b0;
      int1_ctrl_q <= 8'h00;
      ctrl1_q     <= 8'h00;
      ctrl2_q     <= 8'h00;
      ptch_q      <= 16'h0000;
      roll_q      <= 16'h0000;
      yaw_q       <= 16'h0000;
      pend_ptch_q <= 16'h0000;
      pend_roll_q <= 16'h0000;
      pend_yaw_q  <= 16'h0000;
      pend_vld_q  <= 1'b0;
      int_set_q   <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      int_q     <= int_d;
      int_set_q <= cap_en & int1_ctrl_q[1];

      if (cap_en) begin
        ptch_q <= cap_ptch_d;
        roll_q <= cap_roll_d;
        yaw_q  <= cap_yaw_d;
      end

      // Park samples arriving mid-frame; a later pulse overwrites an earlier one.
      if (in_commit) begin
        pend_vld_q <= 1'b0;
      end else if ((state_q == SHIFT) && smpl_vld) begin
        pend_vld_q  <= 1'b1;
        pend_ptch_q <= ptch_rt;
        pend_roll_q <= roll_rt;
        pend_yaw_q  <= yaw_rt;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 8'h00;
          if (ss_fall) begin
            state_q <= SHIFT;
            cnt_q   <= 5'd0;
            rx_q    <= 16'h0000;
            tx_ld_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q <= COMMIT;
            tx_q    <= 8'h00;
          end else if (sclk_rise && !frame_ok) begin
            rx_q  <= {rx_q[14:0], mosi_q[1]};
            cnt_q <= cnt_q + 5'd1;
          end else if (sclk_fall) begin
            if (tx_ld_q) begin
              tx_q <= {tx_q[6:0], 1'b0};
            end else if ((cnt_q == 5'd8) && rx_q[7]) begin
              tx_q    <= rd_dat;
              tx_ld_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (wr_en) begin
            case (rx_q[14:8])
              7'h0D:   int1_ctrl_q <= rx_q[7:0];
              7'h10:   ctrl1_q     <= rx_q[7:0];
              7'h11:   ctrl2_q     <= rx_q[7:0];
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO = tx_q[7];
  assign INT  = int_q;

endmodule

// File: tb/tb_spi_inert_resp.sv
// Directed bench for spi_inert_resp: SPI master model (SCLK idles high, MOSI changes
// on fall, MISO sampled on rise) plus sample strobes; expected values hand-computed.
// Ports of the DUT are all driven/observed here; SCLK half period is 10 clk.
module tb_spi_inert_resp;

  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO, INT;
  logic        smpl_vld;
  logic [15:0] ptch_rt, roll_rt, yaw_rt;

  int n_checks = 0;
  int n_fail   = 0;

  spi_inert_resp dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .INT      (INT),
    .smpl_vld (smpl_vld),
    .ptch_rt  (ptch_rt),
    .roll_rt  (roll_rt),
    .yaw_rt   (yaw_rt)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock bits first..last-1 of a frame, leaving SS_n low and SCLK high.
  task automatic spi_bits(input logic [15:0] frame, input int first, input int last,
                          output logic [15:0] rbits);
    rbits = 16'h0000;
    if (SS_n) begin
      SS_n = 1'b0;
      MOSI = frame[15];
      wait_clk(H);
    end
    for (int i = first; i < last; i++) begin
      SCLK = 1'b0;
      MOSI = frame[15-i];
      wait_clk(H);
      SCLK = 1'b1;
      rbits[15-i] = MISO;
      wait_clk(H);
    end
  endtask

  task automatic spi_end();
    wait_clk(H);
    SS_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_read(input logic [6:0] addr, output logic [15:0] rbits);
    spi_bits({1'b1, addr, 8'h00}, 0, 16, rbits);
    spi_end();
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [15:0] dummy;
    spi_bits({1'b0, addr, data}, 0, 16, dummy);
    spi_end();
  endtask

  task automatic pulse(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y);
    ptch_rt  = p;
    roll_rt  = r;
    yaw_rt   = y;
    smpl_vld = 1'b1;
    wait_clk(1);
    smpl_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; smpl_vld = 1'b0;
    ptch_rt = 16'h0; roll_rt = 16'h0; yaw_rt = 16'h0;
    wait_clk(3);
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", INT); end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_whoami();
    logic [15:0] r;
    spi_read(7'h0F, r);
    n_checks++; if (r !== 16'h006A) begin n_fail++; $display("FAIL whoami: got %h want 006a", r); end
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL whoami_int: got %b want 0", INT); end
  endtask

  task automatic test_sample_int();
    logic [15:0] r;
    spi_write(7'h0D, 8'h02);
    spi_read(7'h0D, r);
    n_checks++; if (r !== 16'h0002) begin n_fail++; $display("FAIL int1_ctrl_rb: got %h want 0002", r); end
    pulse(16'h1234, 16'h5678, 16'hA5C3);
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_early: got %b want 0", INT); end
    wait_clk(1);
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL int_set: got %b want 1", INT); end
    spi_read(7'h22, r);
    n_checks++; if (r !== 16'h0034) begin n_fail++; $display("FAIL ptch_l: got %h want 0034", r); end
    spi_read(7'h23, r);
    n_checks++; if (r !== 16'h0012) begin n_fail++; $display("FAIL ptch_h: got %h want 0012", r); end
    spi_read(7'h24, r);
    n_checks++; if (r !== 16'h0078) begin n_fail++; $display("FAIL roll_l: got %h want 0078", r); end
    spi_read(7'h25, r);
    n_checks++; if (r !== 16'h0056) begin n_fail++; $display("FAIL roll_h: got %h want 0056", r); end
  endtask

  task automatic test_int_clear();
    logic [15:0] r;
    spi_read(7'h26, r);
    n_checks++; if (r !== 16'h00C3) begin n_fail++; $display("FAIL yaw_l: got %h want 00c3", r); end
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL int_after_26: got %b want 1", INT); end
    spi_bits(16'hA700, 0, 16, r);
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL int_before_commit: got %b want 1", INT); end
    n_checks++; if (r !== 16'h00A5) begin n_fail++; $display("FAIL yaw_h: got %h want 00a5", r); end
    spi_end();
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_clear_27: got %b want 0", INT); end
  endtask

  task automatic test_midframe_sample();
    logic [15:0] r1, r2;
    pulse(16'h1234, 16'h5678, 16'h77AA);
    wait_clk(2);
    spi_bits(16'hA700, 0, 10, r1);
    pulse(16'h1234, 16'h5678, 16'h1111);
    wait_clk(2);
    pulse(16'h1234, 16'h5678, 16'hBEEF);
    spi_bits(16'hA700, 10, 16, r2);
    n_checks++; if ((r1 | r2) !== 16'h0077) begin n_fail++; $display("FAIL torn_read: got %h want 0077", r1 | r2); end
    spi_end();
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", INT); end
    spi_read(7'h26, r1);
    n_checks++; if (r1 !== 16'h00EF) begin n_fail++; $display("FAIL pend_last_l: got %h want 00ef", r1); end
    spi_read(7'h27, r1);
    n_checks++; if (r1 !== 16'h00BE) begin n_fail++; $display("FAIL pend_last_h: got %h want 00be", r1); end
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_clear_2: got %b want 0", INT); end
  endtask

  task automatic test_abort_and_map();
    logic [15:0] r;
    pulse(16'h1234, 16'h5678, 16'hA5C3);
    wait_clk(2);
    spi_bits(16'hA700, 0, 12, r);
    spi_end();
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL abort_no_clear: got %b want 1", INT); end
    spi_bits(16'h1055, 0, 12, r);
    spi_end();
    spi_read(7'h10, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL abort_no_write: got %h want 0000", r); end
    spi_write(7'h10, 8'h55);
    spi_read(7'h10, r);
    n_checks++; if (r !== 16'h0055) begin n_fail++; $display("FAIL ctrl1_rb: got %h want 0055", r); end
    spi_write(7'h11, 8'hAB);
    spi_read(7'h11, r);
    n_checks++; if (r !== 16'h00AB) begin n_fail++; $display("FAIL ctrl2_rb: got %h want 00ab", r); end
    spi_write(7'h0F, 8'h00);
    spi_read(7'h0F, r);
    n_checks++; if (r !== 16'h006A) begin n_fail++; $display("FAIL whoami_ro: got %h want 006a", r); end
    spi_write(7'h22, 8'h99);
    spi_read(7'h22, r);
    n_checks++; if (r !== 16'h0034) begin n_fail++; $display("FAIL data_ro: got %h want 0034", r); end
    spi_write(7'h40, 8'h12);
    spi_read(7'h40, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL unmapped: got %h want 0000", r); end
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL int_hold: got %b want 1", INT); end
  endtask

  task automatic test_int_ctrl_write();
    logic [15:0] r;
    spi_write(7'h0D, 8'h00);
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_en_clear: got %b want 0", INT); end
    pulse(16'hCAFE, 16'h5678, 16'hA5C3);
    wait_clk(3);
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_disabled: got %b want 0", INT); end
    spi_read(7'h22, r);
    n_checks++; if (r !== 16'h00FE) begin n_fail++; $display("FAIL cap_disabled: got %h want 00fe", r); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] r;
    spi_write(7'h0D, 8'h02);
    pulse(16'h1234, 16'h5678, 16'hA5C3);
    wait_clk(2);
    n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL pre_rst_int: got %b want 1", INT); end
    spi_bits(16'h8F00, 0, 6, r);
    rst = 1'b1;
    #1;
    n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", INT); end
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b want 0", MISO); end
    wait_clk(2);
    rst = 1'b0;
    wait_clk(5);
    // SS_n never went high: this whole frame must be ignored.
    spi_bits(16'h1077, 0, 16, r);
    spi_end();
    spi_read(7'h10, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL no_fresh_fall: got %h want 0000", r); end
    spi_read(7'h0D, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_int1: got %h want 0000", r); end
    spi_read(7'h22, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h want 0000", r); end
    spi_read(7'h0F, r);
    n_checks++; if (r !== 16'h006A) begin n_fail++; $display("FAIL whoami_after_rst: got %h want 006a", r); end
  endtask

  initial begin
    test_reset();
    test_whoami();
    test_sample_int();
    test_int_clear();
    test_midframe_sample();
    test_abort_and_map();
    test_int_ctrl_write();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_inert_resp.md
SPI_INERT_RESP -- requirements
Module: spi_inert_resp

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port SS_n, input, 1 bit: SPI select from the master, active low, asynchronous to clk.
REQ-004 SHALL have port SCLK, input, 1 bit: SPI clock; idles high; asynchronous to clk.
REQ-005 SHALL have port MOSI, input, 1 bit: master data, stable around SCLK rise.
REQ-006 SHALL have port MISO, output, 1 bit: responder data, changes only after SCLK fall.
REQ-007 SHALL have port INT, output, 1 bit: new-sample-ready flag to the master.
REQ-008 SHALL have port smpl_vld, input, 1 bit: one-clk pulse; new sensor sample present.
REQ-009 SHALL have ports ptch_rt, roll_rt, yaw_rt, input, 16 bits each: raw rate samples.

Function
REQ-010 SHALL pass SS_n, SCLK and MOSI through two-flop synchronizers, with edge detection on synchronized SCLK and SS_n; operation SHALL be guaranteed for SCLK period >= 16 clk.
REQ-011 SHALL implement states IDLE, SHIFT, COMMIT: IDLE->SHIFT on synchronized SS_n fall; SHIFT->COMMIT on synchronized SS_n rise; COMMIT->IDLE after exactly one clk.
REQ-012 SHALL, in SHIFT, shift synchronized MOSI into a 16-bit rx register MSB-first on each synchronized SCLK rise, counting rises with a 5-bit counter cleared on entry to SHIFT and saturating at 16.
REQ-013 SHALL decode the frame as bit15 = R/W (1 = read), bits14:8 = 7-bit address, bits7:0 = write data.
REQ-014 SHALL, for a read, load the 8-bit tx register with the addressed read data on the first SCLK fall after the 8th rise, shift tx left on each later fall, and drive MISO = tx[7].
REQ-015 SHALL drive MISO = 0 in IDLE and during the address byte.
REQ-016 SHALL provide this register map: 0x0F WHO_AM_I, read-only constant 0x6A; 0x0D INT1_CTRL, R/W, 8 bits; 0x10 CTRL1, R/W, 8 bits; 0x11 CTRL2, R/W, 8 bits; 0x22/0x23 ptch L/H, 0x24/0x25 roll L/H, 0x26/0x27 yaw L/H, all read-only.
REQ-017 SHALL return read data 0x00 for unmapped addresses and ignore writes to them and to read-only addresses.
REQ-018 SHALL commit writes only in COMMIT, and only when count == 16 and R/W = 0.
REQ-019 SHALL treat any frame ending with count != 16 as aborted: no write, no INT clear, no other state change.
REQ-020 SHALL, on smpl_vld while IDLE, capture all three samples into the data registers on the same edge.
REQ-021 SHALL, on smpl_vld while in SHIFT or COMMIT, hold the values in a pending buffer and capture them on the COMMIT->IDLE edge, so that a frame never sees torn data; of multiple pending pulses, the last one SHALL win.
REQ-022 SHALL set INT one clk after a capture when INT1_CTRL[1] = 1; a capture while INT1_CTRL[1] = 0 SHALL leave INT unchanged.
REQ-023 SHALL clear INT in COMMIT of a complete read of address 0x27.
REQ-024 SHALL let set win when a set and a clear of INT occur in the same clk.
REQ-025 SHALL make a write of INT1_CTRL[1] = 0 clear INT in the same COMMIT.

Reset
REQ-026 SHALL, on rst high, asynchronously force: state IDLE; counter, rx, tx and pending buffer 0; INT1_CTRL, CTRL1, CTRL2 and all data registers 0x00; MISO 0; INT 0.
REQ-027 SHALL, on rst mid-frame, abandon the frame and require a fresh SS_n fall before any new frame is accepted.

Verification
REQ-028 SHALL cover: after reset, read 0x0F (frame 0x8F00) -> MISO shifts out 0x6A MSB-first over bits 7..0; INT stays 0.
REQ-029 SHALL cover: write 0x0D = 0x02 (frame 0x0D02), then smpl_vld with ptch_rt = 0x1234 -> INT = 1 one clk later; reads of 0x22/0x23 return 0x34/0x12.
REQ-030 SHALL cover: with INT = 1, read 0x26 then 0x27 -> INT stays 1 after the 0x26 frame and clears in COMMIT of the 0x27 frame.
REQ-031 SHALL cover: smpl_vld with yaw_rt = 0xBEEF mid-frame during a 0x27 read -> the frame returns the old yaw H; the new value is captured at frame end; INT ends at 1 (set wins).
REQ-032 SHALL cover: a write 0x10 = 0x55 aborted after 12 SCLK rises -> CTRL1 stays 0x00; a following complete write of 0x10 = 0x55 reads back 0x55.
REQ-033 SHALL cover: rst asserted after 6 SCLK rises of a frame -> all outputs are 0 immediately; the next complete read of 0x0F returns 0x6A.
